// File: rtl/stage4_memory_access.sv
// LEGv8 memory-access stage: ALU pass-through, LDUR/STUR bus transactions, branch resolve, fault detection.
// Latency: non-memory ops 1 cycle after capture; memory ops 1 cycle after the cycle mem_ack is sampled.
// Backpressure: ex_ready is low only while a bus transaction is outstanding (ACCESS); derived from state only.
`ifndef LEGV8_INTEGER_SZ
`define LEGV8_INTEGER_SZ 64
`endif

module stage4_memory_access #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ex_valid,
  output logic                         ex_ready,
  input  logic [`LEGV8_INTEGER_SZ-1:0] ex_alu_result,
  input  logic [`LEGV8_INTEGER_SZ-1:0] ex_store_data,
  input  logic [`LEGV8_INTEGER_SZ-1:0] ex_branch_target,
  input  logic                         ex_zero,
  input  logic                         ex_memread,
  input  logic                         ex_memwrite,
  input  logic                         ex_branch,
  input  logic                         ex_uncond,
  input  logic                         ex_memtoreg,
  input  logic                         ex_regwrite,
  input  logic [4:0]                   ex_rd,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [`LEGV8_INTEGER_SZ-1:0] mem_addr,
  output logic [`LEGV8_INTEGER_SZ-1:0] mem_wdata,
  input  logic                         mem_ack,
  input  logic [`LEGV8_INTEGER_SZ-1:0] mem_rdata,
  output logic                         wb_valid,
  output logic [`LEGV8_INTEGER_SZ-1:0] wb_data,
  output logic [4:0]                   wb_rd,
  output logic                         wb_regwrite,
  output logic                         pc_src,
  output logic [`LEGV8_INTEGER_SZ-1:0] pc_target,
  output logic                         fault
);

  localparam int W = `LEGV8_INTEGER_SZ;
  // Last wait-count value before the timeout fires (counter starts at 0 in ACCESS).
  localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t         state_q, state_d;
  logic [15:0]    wait_q, wait_d;
  logic           memread_q, memread_d;
  logic           memtoreg_q, memtoreg_d;
  logic           regwrite_q, regwrite_d;

  logic           mem_req_q, mem_req_d;
  logic           mem_we_q, mem_we_d;
  logic [W-1:0]   mem_addr_q, mem_addr_d;
  logic [W-1:0]   mem_wdata_q, mem_wdata_d;
  logic           wb_valid_q, wb_valid_d;
  logic [W-1:0]   wb_data_q, wb_data_d;
  logic [4:0]     wb_rd_q, wb_rd_d;
  logic           wb_regwrite_q, wb_regwrite_d;
  logic           pc_src_q, pc_src_d;
  logic [W-1:0]   pc_target_q, pc_target_d;
  logic           fault_q, fault_d;

  logic           xfer;
  logic           is_mem;
  logic           illegal;

  // DONE is a writeback cycle that can already accept the next instruction.
  assign ex_ready = (state_q != ACCESS);
  assign xfer     = ex_valid & ex_ready;
  assign is_mem   = ex_memread | ex_memwrite;
  assign illegal  = (ex_memread & ex_memwrite) | (ex_alu_result[2:0] != 3'b000);

  // Next-state and registered-output logic; pulses default low, data holds.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    memread_d     = memread_q;
    memtoreg_d    = memtoreg_q;
    regwrite_d    = regwrite_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    wb_valid_d    = 1'b0;
    wb_data_d     = wb_data_q;
    wb_rd_d       = wb_rd_q;
    wb_regwrite_d = 1'b0;
    pc_src_d      = 1'b0;
    pc_target_d   = pc_target_q;
    fault_d       = 1'b0;

    if (state_q == DONE) begin
      state_d = IDLE;
    end

    if (state_q == ACCESS) begin
      if (mem_ack) begin
        // Read data is latched straight into the writeback register.
        state_d       = DONE;
        mem_req_d     = 1'b0;
        mem_we_d      = 1'b0;
        wb_valid_d    = 1'b1;
        wb_data_d     = memtoreg_q ? mem_rdata : mem_addr_q;
        wb_regwrite_d = regwrite_q & memread_q;
      end else if (wait_q == TIMEOUT_LAST) begin
        state_d       = DONE;
        mem_req_d     = 1'b0;
        mem_we_d      = 1'b0;
        wb_valid_d    = 1'b1;
        wb_data_d     = mem_addr_q;
        fault_d       = 1'b1;
      end else begin
        wait_d = wait_q + 16'd1;
      end
    end else if (xfer) begin
      // rd is stable until writeback since no transfer is taken during ACCESS.
      wb_rd_d     = ex_rd;
      pc_src_d    = (ex_branch & ex_zero) | ex_uncond;
      pc_target_d = ex_branch_target;
      if (!is_mem) begin
        state_d       = IDLE;
        wb_valid_d    = 1'b1;
        wb_data_d     = ex_alu_result;
        wb_regwrite_d = ex_regwrite;
      end else if (illegal) begin
        state_d    = IDLE;
        wb_valid_d = 1'b1;
        wb_data_d  = ex_alu_result;
        fault_d    = 1'b1;
      end else begin
        state_d     = ACCESS;
        wait_d      = 16'd0;
        memread_d   = ex_memread;
        memtoreg_d  = ex_memtoreg;
        regwrite_d  = ex_regwrite;
        mem_req_d   = 1'b1;
        mem_we_d    = ex_memwrite;
        mem_addr_d  = ex_alu_result;
        mem_wdata_d = ex_store_data;
      end
    end
  end

  // State and output registers; reset abandons any outstanding transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wait_q        <= 16'd0;
      memread_q     <= 1'b0;
      memtoreg_q    <= 1'b0;
      regwrite_q    <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_rd_q       <= 5'd0;
      wb_regwrite_q <= 1'b0;
      pc_src_q      <= 1'b0;
      pc_target_q   <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      memread_q     <= memread_d;
      memtoreg_q    <= memtoreg_d;
      regwrite_q    <= regwrite_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      wb_valid_q    <= wb_valid_d;
      wb_data_q     <= wb_data_d;
      wb_rd_q       <= wb_rd_d;
      wb_regwrite_q <= wb_regwrite_d;
      pc_src_q      <= pc_src_d;
      pc_target_q   <= pc_target_d;
      fault_q       <= fault_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign wb_rd       = wb_rd_q;
  assign wb_regwrite = wb_regwrite_q;
  assign pc_src      = pc_src_q;
  assign pc_target   = pc_target_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_stage4_memory_access.sv
// Bench for stage4_memory_access: directed vectors, expected writebacks and branch pulses queued at issue.
// Latency: monitor compares at each falling edge where wb_valid / pc_src / fault is seen.
// Backpressure: stimulus only issues when ex_ready is high and drives mem_ack by hand.
`ifndef LEGV8_INTEGER_SZ
`define LEGV8_INTEGER_SZ 64
`endif

module tb_stage4_memory_access;

  localparam int W = `LEGV8_INTEGER_SZ;

  typedef struct {
    logic [W-1:0] data;
    logic [4:0]   rd;
    logic         regwrite;
    logic         flt;
    logic         chk_data;
  } wb_exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ex_valid = 1'b0;
  logic         ex_ready;
  logic [W-1:0] ex_alu_result = '0;
  logic [W-1:0] ex_store_data = '0;
  logic [W-1:0] ex_branch_target = '0;
  logic         ex_zero = 1'b0, ex_memread = 1'b0, ex_memwrite = 1'b0, ex_branch = 1'b0;
  logic         ex_uncond = 1'b0, ex_memtoreg = 1'b0, ex_regwrite = 1'b0;
  logic [4:0]   ex_rd = 5'd0;
  logic         mem_req, mem_we;
  logic [W-1:0] mem_addr, mem_wdata;
  logic         mem_ack = 1'b0;
  logic [W-1:0] mem_rdata = '0;
  logic         wb_valid;
  logic [W-1:0] wb_data;
  logic [4:0]   wb_rd;
  logic         wb_regwrite;
  logic         pc_src;
  logic [W-1:0] pc_target;
  logic         fault;

  int checks = 0;
  int errors = 0;
  wb_exp_t      wb_q[$];
  logic [W-1:0] pc_q[$];

  stage4_memory_access #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_branch_target(ex_branch_target),
    .ex_zero(ex_zero), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_branch(ex_branch), .ex_uncond(ex_uncond), .ex_memtoreg(ex_memtoreg),
    .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .pc_src(pc_src), .pc_target(pc_target), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic void chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endfunction

  function automatic void chk64(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic push_wb(input logic [W-1:0] data, input logic [4:0] rd,
                         input logic rw, input logic flt, input logic cd);
    wb_exp_t e;
    e.data = data; e.rd = rd; e.regwrite = rw; e.flt = flt; e.chk_data = cd;
    wb_q.push_back(e);
  endtask

  // Drives one instruction at a falling edge; returns one cycle after the capture edge.
  task automatic issue(input logic [W-1:0] alu, input logic [W-1:0] sd, input logic [W-1:0] tgt,
                       input logic mr, input logic mw, input logic br, input logic zr,
                       input logic un, input logic m2r, input logic rw, input logic [4:0] rd);
    chk1("ex_ready_at_issue", ex_ready, 1'b1);
    ex_valid = 1'b1; ex_alu_result = alu; ex_store_data = sd; ex_branch_target = tgt;
    ex_memread = mr; ex_memwrite = mw; ex_branch = br; ex_zero = zr; ex_uncond = un;
    ex_memtoreg = m2r; ex_regwrite = rw; ex_rd = rd;
    @(negedge clk);
    ex_valid = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0; ex_branch = 1'b0;
    ex_zero = 1'b0; ex_uncond = 1'b0; ex_memtoreg = 1'b0; ex_regwrite = 1'b0;
  endtask

  // Monitor: every writeback, fault and branch pulse must match a queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_valid) begin
        chk1("wb_expected", wb_q.size() != 0, 1'b1);
        if (wb_q.size() != 0) begin
          wb_exp_t e;
          e = wb_q.pop_front();
          chk64("wb_rd", {{(W-5){1'b0}}, wb_rd}, {{(W-5){1'b0}}, e.rd});
          chk1("wb_regwrite", wb_regwrite, e.regwrite);
          chk1("wb_fault", fault, e.flt);
          if (e.chk_data) chk64("wb_data", wb_data, e.data);
        end
      end else if (fault) begin
        chk1("fault_without_wb", fault, 1'b0);
      end
      if (pc_src) begin
        chk1("pc_expected", pc_q.size() != 0, 1'b1);
        if (pc_q.size() != 0) chk64("pc_target", pc_target, pc_q.pop_front());
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk1("rst_wb_regwrite", wb_regwrite, 1'b0);
    chk1("rst_pc_src", pc_src, 1'b0);
    chk1("rst_fault", fault, 1'b0);
    chk1("rst_ex_ready", ex_ready, 1'b1);
    chk64("rst_wb_data", wb_data, '0);
    chk64("rst_mem_addr", mem_addr, '0);
    chk64("rst_pc_target", pc_target, '0);

    // ALU op accepted in the first clock after reset release
    rst_n = 1'b1;
    push_wb(64'h2A, 5'd3, 1'b1, 1'b0, 1'b1);
    issue(64'h2A, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0, 1, 5'd3);
    chk1("alu_latency", wb_valid, 1'b1);

    // Back-to-back ALU op with unconditional branch, no register write
    push_wb(64'h1234_5678_9ABC_DEF0, 5'd7, 1'b0, 1'b0, 1'b1);
    pc_q.push_back(64'h200);
    issue(64'h1234_5678_9ABC_DEF0, 64'h0, 64'h200, 0, 0, 0, 0, 1, 0, 0, 5'd7);
    @(negedge clk);

    // LDUR: three wait cycles then ack on the fourth (boundary of ACK_TIMEOUT=4)
    mem_rdata = 64'h1111_1111;
    push_wb(64'hDEAD_BEEF, 5'd5, 1'b1, 1'b0, 1'b1);
    issue(64'h100, 64'h0, 64'h0, 1, 0, 0, 0, 0, 1, 1, 5'd5);
    for (int i = 0; i < 3; i++) begin
      chk1("ld_req", mem_req, 1'b1);
      chk1("ld_we", mem_we, 1'b0);
      chk64("ld_addr", mem_addr, 64'h100);
      chk1("ld_ex_ready", ex_ready, 1'b0);
      @(negedge clk);
    end
    chk1("ld_req_at_ack", mem_req, 1'b1);
    chk64("ld_addr_at_ack", mem_addr, 64'h100);
    mem_ack = 1'b1; mem_rdata = 64'hDEAD_BEEF;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 64'h2222_2222;
    chk1("ld_wb_latency", wb_valid, 1'b1);
    chk1("ld_req_dropped", mem_req, 1'b0);
    chk1("ld_done_ex_ready", ex_ready, 1'b1);
    @(negedge clk);

    // STUR with immediate ack: stores never write back
    push_wb(64'h08, 5'd9, 1'b0, 1'b0, 1'b1);
    issue(64'h08, 64'h55, 64'h0, 0, 1, 0, 0, 0, 0, 1, 5'd9);
    chk1("st_req", mem_req, 1'b1);
    chk1("st_we", mem_we, 1'b1);
    chk64("st_addr", mem_addr, 64'h08);
    chk64("st_wdata", mem_wdata, 64'h55);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk1("st_req_dropped", mem_req, 1'b0);
    @(negedge clk);

    // Misaligned load: no bus request, fault, no register write
    push_wb(64'h103, 5'd4, 1'b0, 1'b1, 1'b0);
    issue(64'h103, 64'h0, 64'h0, 1, 0, 0, 0, 0, 1, 1, 5'd4);
    chk1("mis_no_req", mem_req, 1'b0);
    chk1("mis_fault", fault, 1'b1);
    @(negedge clk);
    chk1("mis_no_req_later", mem_req, 1'b0);

    // Both memread and memwrite: illegal
    push_wb(64'h10, 5'd6, 1'b0, 1'b1, 1'b0);
    issue(64'h10, 64'h0, 64'h0, 1, 1, 0, 0, 0, 1, 1, 5'd6);
    chk1("ill_no_req", mem_req, 1'b0);
    @(negedge clk);

    // Timeout: no ack for ACK_TIMEOUT=4 cycles
    push_wb(64'h200, 5'd2, 1'b0, 1'b1, 1'b0);
    issue(64'h200, 64'h0, 64'h0, 1, 0, 0, 0, 0, 1, 1, 5'd2);
    for (int i = 0; i < 4; i++) begin
      chk1("to_req_held", mem_req, 1'b1);
      @(negedge clk);
    end
    chk1("to_req_dropped", mem_req, 1'b0);
    chk1("to_fault", fault, 1'b1);
    chk1("to_ex_ready", ex_ready, 1'b1);

    // Spurious ack outside ACCESS is ignored
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk1("spur_no_wb", wb_valid, 1'b0);
    chk1("spur_no_req", mem_req, 1'b0);

    // CBZ taken, then not taken
    push_wb(64'h0, 5'd0, 1'b0, 1'b0, 1'b1);
    pc_q.push_back(64'h40);
    issue(64'h0, 64'h0, 64'h40, 0, 0, 1, 1, 0, 0, 0, 5'd0);
    chk1("cbz_pc_src", pc_src, 1'b1);
    push_wb(64'h5, 5'd0, 1'b0, 1'b0, 1'b1);
    issue(64'h5, 64'h0, 64'h80, 0, 0, 1, 0, 0, 0, 0, 5'd0);
    chk1("cbnz_no_pc_src", pc_src, 1'b0);
    @(negedge clk);

    // Reset pulsed mid-ACCESS abandons the transaction
    issue(64'h300, 64'h0, 64'h0, 1, 0, 0, 0, 0, 1, 1, 5'd8);
    chk1("rst_acc_req", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_acc_req_drop", mem_req, 1'b0);
    chk1("rst_acc_no_wb", wb_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk1("post_rst_req", mem_req, 1'b0);
    chk1("post_rst_ex_ready", ex_ready, 1'b1);

    // Normal operation resumes after reset
    push_wb(64'h77, 5'd1, 1'b1, 1'b0, 1'b1);
    issue(64'h77, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0, 1, 5'd1);
    repeat (2) @(negedge clk);

    chk1("wb_queue_drained", wb_q.size() == 0, 1'b1);
    chk1("pc_queue_drained", pc_q.size() == 0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
